// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the execute stage to a request/ack memory port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned ops are reported and dropped instead of issued.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_we,
    input  logic [1:0]  ex_size,
    input  logic        ex_uns,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic [31:0] misalign_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic [31:0] misalign_addr_q, misalign_addr_d;
    logic        trap_s;

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   store_be = 4'b0001 << lo;
            2'b01:   store_be = lo[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    // Lane select then sign/zero extend; the half lane ignores addr[0] on purpose.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] lo, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*lo +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   load_extract = {{24{b[7] & ~uns}}, b};
            2'b01:   load_extract = {{16{h[15] & ~uns}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    // Next-state and next-output computation for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d         = state_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_be_d        = mem_be_q;
        mem_wdata_d     = mem_wdata_q;
        size_d          = size_q;
        uns_d           = uns_q;
        lo_d            = lo_q;
        rd_d            = rd_q;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = 32'd0;
        misalign_d      = 1'b0;
        misalign_addr_d = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_s          = is_misaligned(ex_size, ex_addr[1:0]);
`else
        trap_s          = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    size_d = ex_size;
                    uns_d  = ex_uns;
                    lo_d   = ex_addr[1:0];
                    rd_d   = ex_rd;
                    if (trap_s) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = ex_addr;
                        state_d         = IDLE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = ex_we;
                        mem_addr_d  = {ex_addr[31:2], 2'b00};
                        mem_be_d    = ex_we ? store_be(ex_size, ex_addr[1:0]) : 4'b1111;
                        mem_wdata_d = ex_we ? store_data(ex_size, ex_wdata) : 32'd0;
                        state_d     = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack && mem_req_q) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_extract(size_q, uns_q, lo_q, mem_rdata);
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ready_q         <= 1'b1;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'd0;
            mem_be_q        <= 4'd0;
            mem_wdata_q     <= 32'd0;
            size_q          <= 2'd0;
            uns_q           <= 1'b0;
            lo_q            <= 2'd0;
            rd_q            <= 5'd0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= 5'd0;
            wb_data_q       <= 32'd0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_be_q        <= mem_be_d;
            mem_wdata_q     <= mem_wdata_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            lo_q            <= lo_d;
            rd_q            <= rd_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign ex_ready      = ready_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven directed bench for load_store_unit plus hand sequences for reset and misalignment.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_we, ex_uns;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, misalign_addr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wb;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_we(ex_we),
        .ex_size(ex_size), .ex_uns(ex_uns), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (ex_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_ready", {31'd0, ex_ready}, 32'd1);
    endtask

    task automatic drive_op(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        ex_valid = 1'b1;
        ex_we    = we;
        ex_size  = size;
        ex_uns   = uns;
        ex_addr  = addr;
        ex_wdata = wdata;
        ex_rd    = rd;
    endtask

    // Called at a negedge; leaves the bench at the negedge of the cycle after DONE.
    task automatic run_vec(input vec_t v);
        wait_ready();
        drive_op(v.we, v.size, v.uns, v.addr, v.wdata, v.rd);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i <= v.delay; i++) begin
            chk("mem_req",  {31'd0, mem_req}, 32'd1);
            chk("mem_addr", mem_addr, v.e_addr);
            chk("mem_be",   {28'd0, mem_be}, {28'd0, v.e_be});
            chk("mem_we",   {31'd0, mem_we}, {31'd0, v.we});
            if (v.we) chk("mem_wdata", mem_wdata, v.e_wdata);
            chk("busy_ready", {31'd0, ex_ready}, 32'd0);
            chk("busy_wb",    {31'd0, wb_valid}, 32'd0);
            chk("misalign0",  {31'd0, misalign}, 32'd0);
            if (i == v.delay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_A5A5;
        end
        chk("done_wb_valid", {31'd0, wb_valid}, {31'd0, v.e_wb});
        chk("done_wb_data",  wb_data, v.e_data);
        if (v.e_wb) chk("done_wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
        chk("done_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("done_ready",    {31'd0, ex_ready}, 32'd0);
        @(negedge clk);
        chk("after_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("after_wb_data",  wb_data, 32'd0);
        chk("after_ready",    {31'd0, ex_ready}, 32'd1);
    endtask

    initial begin
        //           we    size   uns   addr          wdata         rd     rdata         dly e_addr        e_be     e_wdata       wb    e_data
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd0, 32'h0,        0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,        5'd5, 32'h8001_1234, 0, 32'h0000_2000, 4'b1111, 32'h0,        1'b1, 32'hFFFF_8001};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        5'd5, 32'h8001_1234, 0, 32'h0000_2000, 4'b1111, 32'h0,        1'b1, 32'h0000_8001};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0,        5'd7, 32'hDEAD_BEEF, 4, 32'h0000_4000, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0,        5'd3, 32'h1234_80FF, 1, 32'h0000_5000, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_5003, 32'h0,        5'd9, 32'hC100_0000, 0, 32'h0000_5000, 4'b1111, 32'h0,        1'b1, 32'h0000_00C1};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'h1234_ABCD, 5'd0, 32'h0,        0, 32'h0000_6000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_6000, 32'h0000_5A5A, 5'd0, 32'h0,        0, 32'h0000_6000, 4'b0011, 32'h5A5A_5A5A, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_7004, 32'hCAFE_F00D, 5'd0, 32'h0,        2, 32'h0000_7004, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0,        5'd31, 32'h8001_7FFE, 0, 32'h0000_2000, 4'b1111, 32'h0,       1'b1, 32'h0000_7FFE};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h1234_5677, 5'd0, 32'h0,        0, 32'h0000_1000, 4'b0010, 32'h7777_7777, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_8008, 32'h0,        5'd12, 32'h0123_4567, 0, 32'h0000_8008, 4'b1111, 32'h0,       1'b1, 32'h0123_4567};

        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        ex_valid = 1'b0; ex_we = 1'b0; ex_size = 2'b00; ex_uns = 1'b0;
        ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready",    {31'd0, ex_ready}, 32'd1);
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be",   {28'd0, mem_be}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) run_vec(vecs[k]);

        // Misaligned word load at 0x3001.
`ifdef LSU_MISALIGN_TRAP_EN
        wait_ready();
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 5'd4);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("trap_misalign",      {31'd0, misalign}, 32'd1);
        chk("trap_misalign_addr", misalign_addr, 32'h0000_3001);
        chk("trap_mem_req",       {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("trap_pulse_end", {31'd0, misalign}, 32'd0);
        chk("trap_no_req",    {31'd0, mem_req}, 32'd0);
        chk("trap_no_wb",     {31'd0, wb_valid}, 32'd0);
        chk("trap_ready",     {31'd0, ex_ready}, 32'd1);
`else
        begin
            vec_t mv;
            mv = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd4, 32'h1122_3344, 0,
                   32'h0000_3000, 4'b1111, 32'h0, 1'b1, 32'h1122_3344};
            run_vec(mv);
            chk("noTrap_misalign_addr", misalign_addr, 32'd0);
        end
`endif

        // Reset while BUSY, then a late ack must be ignored.
        wait_ready();
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'd0, 5'd6);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rb_busy_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rb_req_cleared",  {31'd0, mem_req}, 32'd0);
        chk("rb_ready",        {31'd0, ex_ready}, 32'd1);
        chk("rb_addr_cleared", mem_addr, 32'd0);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk("rb_late_ack_wb",  {31'd0, wb_valid}, 32'd0);
            chk("rb_late_ack_req", {31'd0, mem_req}, 32'd0);
            chk("rb_late_ready",   {31'd0, ex_ready}, 32'd1);
        end
        mem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
